// File: rtl/testdrive_axi4_write_master.sv
// Single-outstanding AXI4 INCR write burst master: command in, one AW, N pass-through W beats, B -> DONE pulse.
// Bursts that would cross a 4KB boundary are rejected locally with DONE_RESP=2'b10 and no bus traffic.
module testdrive_axi4_write_master #(
  parameter int C_THREAD_ID_WIDTH = 1,
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_DATA_WIDTH      = 128
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           CMD_VALID,
  output logic                           CMD_READY,
  input  logic [C_ADDR_WIDTH-1:0]        CMD_ADDR,
  input  logic [7:0]                     CMD_LEN,
  input  logic [C_THREAD_ID_WIDTH-1:0]   CMD_ID,
  input  logic                           DIN_VALID,
  output logic                           DIN_READY,
  input  logic [C_DATA_WIDTH-1:0]        DIN_DATA,
  input  logic [C_DATA_WIDTH/8-1:0]      DIN_STRB,
  output logic                           DONE,
  output logic [1:0]                     DONE_RESP,
  output logic [C_THREAD_ID_WIDTH-1:0]   AWID,
  output logic [C_ADDR_WIDTH-1:0]        AWADDR,
  output logic [7:0]                     AWLEN,
  output logic [2:0]                     AWSIZE,
  output logic [1:0]                     AWBURST,
  output logic [0:0]                     AWLOCK,
  output logic [3:0]                     AWCACHE,
  output logic [2:0]                     AWPROT,
  output logic [3:0]                     AWREGION,
  output logic [3:0]                     AWQOS,
  output logic                           AWVALID,
  input  logic                           AWREADY,
  output logic [C_THREAD_ID_WIDTH-1:0]   WID,
  output logic [C_DATA_WIDTH-1:0]        WDATA,
  output logic [C_DATA_WIDTH/8-1:0]      WSTRB,
  output logic                           WLAST,
  output logic                           WVALID,
  input  logic                           WREADY,
  input  logic [C_THREAD_ID_WIDTH-1:0]   BID,
  input  logic [1:0]                     BRESP,
  input  logic                           BVALID,
  output logic                           BREADY
);
  localparam int C_BYTES = C_DATA_WIDTH / 8;
  localparam int C_SIZE  = $clog2(C_BYTES);
  localparam logic [C_ADDR_WIDTH-1:0] C_ALIGN_MASK = ~(C_ADDR_WIDTH'(C_BYTES - 1));

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                         r_state, w_state_nxt;
  logic                           r_cmd_rdy;
  logic                           r_done;
  logic [1:0]                     r_done_resp;
  logic [C_ADDR_WIDTH-1:0]        r_addr;
  logic [7:0]                     r_len;
  logic [C_THREAD_ID_WIDTH-1:0]   r_id;
  logic [7:0]                     r_cnt;

  logic                           w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic                           w_reject, w_done_nxt;
  logic [C_ADDR_WIDTH-1:0]        w_addr_al;
  logic [19:0]                    w_end;

  // Burst end offset within the 4KB page; wide enough for 256 beats of 1024-bit data.
  assign w_addr_al = CMD_ADDR & C_ALIGN_MASK;
  assign w_end     = 20'(w_addr_al[11:0]) + (20'(CMD_LEN) + 20'd1) * 20'(C_BYTES);
  assign w_reject  = (w_end > 20'd4096);

  assign w_cmd_hs   = CMD_VALID && r_cmd_rdy;
  assign w_aw_hs    = AWVALID && AWREADY;
  assign w_w_hs     = WVALID && WREADY;
  assign w_b_hs     = BVALID && BREADY;
  assign w_done_nxt = (w_cmd_hs && w_reject) || w_b_hs;

  assign CMD_READY = r_cmd_rdy;
  assign DONE      = r_done;
  assign DONE_RESP = r_done_resp;

  assign AWID     = r_id;
  assign AWADDR   = r_addr;
  assign AWLEN    = r_len;
  assign AWSIZE   = 3'(C_SIZE);
  assign AWBURST  = 2'b01;
  assign AWLOCK   = 1'b0;
  assign AWCACHE  = 4'b0011;
  assign AWPROT   = 3'b000;
  assign AWREGION = 4'b0000;
  assign AWQOS    = 4'b0000;
  assign AWVALID  = (r_state == S_ADDR);

  assign WID       = r_id;
  assign WDATA     = DIN_DATA;
  assign WSTRB     = DIN_STRB;
  assign WVALID    = (r_state == S_DATA) && DIN_VALID;
  assign DIN_READY = (r_state == S_DATA) && WREADY;
  assign WLAST     = (r_state == S_DATA) && (r_cnt == r_len);
  assign BREADY    = (r_state == S_RESP);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_cmd_hs && !w_reject) w_state_nxt = S_ADDR;
      S_ADDR: if (AWREADY) w_state_nxt = S_DATA;
      S_DATA: if (w_w_hs && WLAST) w_state_nxt = S_RESP;
      S_RESP: if (BVALID) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_cmd_rdy   <= 1'b0;
      r_done      <= 1'b0;
      r_done_resp <= 2'b00;
      r_addr      <= '0;
      r_len       <= 8'd0;
      r_id        <= '0;
      r_cnt       <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      // Ready is withheld during the DONE cycle so a new command lands no earlier than the cycle after.
      r_cmd_rdy   <= (w_state_nxt == S_IDLE) && !w_done_nxt;
      r_done      <= w_done_nxt;
      r_done_resp <= w_b_hs ? BRESP : (w_done_nxt ? 2'b10 : 2'b00);
      if (w_cmd_hs && !w_reject) begin
        r_addr <= w_addr_al;
        r_len  <= CMD_LEN;
        r_id   <= CMD_ID;
      end
      if (w_aw_hs)     r_cnt <= 8'd0;
      else if (w_w_hs) r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST && w_b_hs)
      assert (BID == r_id) else $warning("BID %0h differs from burst ID %0h", BID, r_id);
  end
endmodule
